// File: rtl/dispatch_batch_scheduler.sv
// dispatch_batch_scheduler
//   Picks which issue batch (BLOCK_SIZE consecutive issue slots) owns the
//   dispatch datapath and holds it until the dispatch blocks report done,
//   or until the batch loses all its valid slots (abort). Lowest index wins,
//   except that a batch which has lost STARVE_LIMIT decisions is force-granted.
//
//   Optional feature: define DISPATCH_SCHED_PERF_EN to add perf_grants and
//   perf_hold_cycles.
//
// Ports
//   clk              clock
//   reset            synchronous, active-high
//   dispatch_valid   [ISSUE_WIDTH] per-slot valid; a batch requests if any slot is set
//   batch_done       current batch has released all packets on all blocks
//   batch_valid      a batch is selected (BUSY)
//   batch_idx        [BATCH_W] selected batch
//   batch_onehot     [BATCH_COUNT] one-hot of batch_idx, zero when !batch_valid
//   perf_grants      [32] decisions that produced a winner (perf build only)
//   perf_hold_cycles [32] BUSY cycles with batch_done low (perf build only)

// Per-batch age tracker. The age counts lost decisions and saturates at
// STARVE_LIMIT; 'starved' flags a candidate that must be force-granted.
module dispatch_batch_age_cell #(
  parameter int AGE_W        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic upd,     // decision with a winner this cycle
  input  logic win,     // this batch is the winner
  input  logic req,     // this batch is requesting
  input  logic excl,    // this batch is the current owner at a BUSY decision
  input  logic cand,    // this batch is a candidate
  output logic starved
);
  localparam logic [AGE_W-1:0] LIMIT = AGE_W'(STARVE_LIMIT);

  logic [AGE_W-1:0] age;

  always_ff @(posedge clk) begin
    if (reset) begin
      age <= '0;
    end else if (upd) begin
      if (win)
        age <= '0;
      else if (req && !excl && age != LIMIT)
        age <= age + 1'b1;
    end
  end

  assign starved = cand && (age == LIMIT);
endmodule

module dispatch_batch_scheduler #(
  parameter  int ISSUE_WIDTH  = 4,
  parameter  int BLOCK_SIZE   = 1,
  parameter  int STARVE_LIMIT = 8,
  localparam int BATCH_COUNT  = ISSUE_WIDTH / BLOCK_SIZE,
  localparam int BATCH_W      = (BATCH_COUNT > 1) ? $clog2(BATCH_COUNT) : 1,
  localparam int AGE_W        = (STARVE_LIMIT > 0) ? (($clog2(STARVE_LIMIT + 1) > 1) ? $clog2(STARVE_LIMIT + 1) : 1) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ISSUE_WIDTH-1:0] dispatch_valid,
  input  logic                   batch_done,
  output logic                   batch_valid,
  output logic [BATCH_W-1:0]     batch_idx,
  output logic [BATCH_COUNT-1:0] batch_onehot
`ifdef DISPATCH_SCHED_PERF_EN
  ,
  output logic [31:0]            perf_grants,
  output logic [31:0]            perf_hold_cycles
`endif
);

  if (ISSUE_WIDTH % BLOCK_SIZE != 0) begin : g_bad_cfg
    $error("BLOCK_SIZE must divide ISSUE_WIDTH");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state;
  logic [BATCH_COUNT-1:0] req;
  logic [BATCH_COUNT-1:0] cand;
  logic [BATCH_COUNT-1:0] starved;
  logic [BATCH_COUNT-1:0] pool;
  logic [BATCH_COUNT-1:0] win_oh;
  logic [BATCH_W-1:0]     win_idx;
  logic                   busy;
  logic                   cur_req;
  logic                   decide;
  logic                   grant;

  for (genvar b = 0; b < BATCH_COUNT; b++) begin : g_req
    assign req[b] = |dispatch_valid[b*BLOCK_SIZE +: BLOCK_SIZE];
  end

  // batch_onehot is gated by batch_valid, so inside BUSY it is exactly the
  // current batch mask; this avoids indexing req with a possibly
  // out-of-range batch_idx when BATCH_COUNT is not a power of two.
  always_comb begin
    busy    = (state == BUSY);
    cur_req = |(req & batch_onehot);
    decide  = busy ? (batch_done || !cur_req) : (|req);
    cand    = busy ? (req & ~batch_onehot) : req;
    // Current batch alone still requesting: it is re-granted.
    if (busy && cand == '0 && cur_req)
      cand = batch_onehot;
    grant   = decide && (|cand);
  end

  // Kept apart from the candidate block: starved depends on cand.
  always_comb begin
    pool    = (|starved) ? starved : cand;
    win_idx = '0;
    win_oh  = '0;
    for (int b = BATCH_COUNT - 1; b >= 0; b--) begin
      if (pool[b]) begin
        win_idx   = BATCH_W'(b);
        win_oh    = '0;
        win_oh[b] = 1'b1;
      end
    end
  end

  if (BATCH_COUNT > 1 && STARVE_LIMIT > 0) begin : g_age
    for (genvar b = 0; b < BATCH_COUNT; b++) begin : g_cell
      dispatch_batch_age_cell #(
        .AGE_W        (AGE_W),
        .STARVE_LIMIT (STARVE_LIMIT)
      ) u_cell (
        .clk     (clk),
        .reset   (reset),
        .upd     (grant),
        .win     (win_oh[b]),
        .req     (req[b]),
        .excl    (busy & batch_onehot[b]),
        .cand    (cand[b]),
        .starved (starved[b])
      );
    end
  end else begin : g_no_age
    assign starved = '0;
  end

  // batch_idx is held when falling back to IDLE; it only moves on a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      batch_valid  <= 1'b0;
      batch_idx    <= '0;
      batch_onehot <= '0;
    end else if (decide) begin
      if (grant) begin
        state        <= BUSY;
        batch_valid  <= 1'b1;
        batch_idx    <= win_idx;
        batch_onehot <= win_oh;
      end else begin
        state        <= IDLE;
        batch_valid  <= 1'b0;
        batch_onehot <= '0;
      end
    end
  end

`ifdef DISPATCH_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_grants      <= '0;
      perf_hold_cycles <= '0;
    end else begin
      if (grant)
        perf_grants <= perf_grants + 32'd1;
      if (busy && !batch_done)
        perf_hold_cycles <= perf_hold_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_batch_scheduler.sv
// Randomized scoreboard bench for dispatch_batch_scheduler (4 slots, 1 slot per
// batch, starve limit 2). The stimulus process drives inputs on the falling
// edge, advances a list-based reference model and queues the outputs expected
// after the next rising edge; the monitor pops and compares after each rising
// edge.
module tb_dispatch_batch_scheduler;
  localparam int IW = 4;
  localparam int BS = 1;
  localparam int SL = 2;
  localparam int NB = IW / BS;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [IW-1:0] dispatch_valid = '0;
  logic          batch_done = 1'b0;
  logic          batch_valid;
  logic [1:0]    batch_idx;
  logic [NB-1:0] batch_onehot;
`ifdef DISPATCH_SCHED_PERF_EN
  logic [31:0]   perf_grants;
  logic [31:0]   perf_hold_cycles;
`endif

  dispatch_batch_scheduler #(
    .ISSUE_WIDTH  (IW),
    .BLOCK_SIZE   (BS),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .dispatch_valid (dispatch_valid),
    .batch_done     (batch_done),
    .batch_valid    (batch_valid),
    .batch_idx      (batch_idx),
    .batch_onehot   (batch_onehot)
`ifdef DISPATCH_SCHED_PERF_EN
    ,
    .perf_grants      (perf_grants),
    .perf_hold_cycles (perf_hold_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          vld;
    logic [NB-1:0] oh;
    logic [1:0]    idx;
    bit            chk_idx;
    logic [31:0]   pg;
    logic [31:0]   ph;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  bit          m_busy;
  int          m_idx;
  int          m_age[NB];
  bit          m_after_rst;
  logic [31:0] m_pg;
  logic [31:0] m_ph;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input logic [IW-1:0] dv, input bit done);
    bit   req[NB];
    bit   any;
    bit   decide;
    int   cand[$];
    int   w;
    exp_t e;
    any = 0;
    for (int b = 0; b < NB; b++) begin
      req[b] = |dv[b*BS +: BS];
      any |= req[b];
    end
    if (rst) begin
      m_busy = 0; m_idx = 0; m_after_rst = 1; m_pg = 0; m_ph = 0;
      for (int b = 0; b < NB; b++) m_age[b] = 0;
    end else begin
      if (m_busy && !done) m_ph = m_ph + 32'd1;
      decide = m_busy ? (done || !req[m_idx]) : any;
      if (decide) begin
        for (int b = 0; b < NB; b++)
          if (req[b] && !(m_busy && b == m_idx)) cand.push_back(b);
        if (m_busy && cand.size() == 0 && req[m_idx]) cand.push_back(m_idx);
        if (cand.size() == 0) begin
          m_busy = 0;
        end else begin
          w = cand[0];
          foreach (cand[i])
            if (m_age[cand[i]] == SL) begin w = cand[i]; break; end
          for (int b = 0; b < NB; b++) begin
            if (b == w) m_age[b] = 0;
            else if (req[b] && !(m_busy && b == m_idx) && m_age[b] < SL) m_age[b]++;
          end
          m_pg = m_pg + 32'd1;
          m_busy = 1; m_idx = w; m_after_rst = 0;
        end
      end
    end
    e.vld     = m_busy;
    e.oh      = m_busy ? NB'(1 << m_idx) : '0;
    e.idx     = 2'(m_idx);
    e.chk_idx = m_busy || m_after_rst;
    e.pg      = m_pg;
    e.ph      = m_ph;
    q.push_back(e);
  endtask

  task automatic step(input bit rst, input logic [IW-1:0] dv, input bit done);
    @(negedge clk);
    reset          = rst;
    dispatch_valid = dv;
    batch_done     = done;
    model_step(rst, dv, done);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("batch_valid", 32'(batch_valid), 32'(e.vld));
        chk("batch_onehot", 32'(batch_onehot), 32'(e.oh));
        if (e.chk_idx) chk("batch_idx", 32'(batch_idx), 32'(e.idx));
`ifdef DISPATCH_SCHED_PERF_EN
        chk("perf_grants", perf_grants, e.pg);
        chk("perf_hold_cycles", perf_hold_cycles, e.ph);
`endif
      end
    end
  end

  // Stimulus
  initial begin
    logic [IW-1:0] dv;
    int            n;
    repeat (2) step(1, '0, 0);
    repeat (10) step(0, '0, 0);                  // no requests
    repeat (3) step(0, 4'b0101, 0);              // hold until done, then switch
    step(0, 4'b0101, 1);
    repeat (2) step(0, 4'b0101, 0);
    step(0, 4'b0000, 1);
    repeat (3) step(0, 4'b0010, 0);              // abort: valid drops without done
    repeat (2) step(0, 4'b0000, 0);
    repeat (2) step(0, 4'b0010, 0);              // sole requester re-grant
    repeat (2) step(0, 4'b0010, 1);
    step(0, 4'b0000, 1);
    repeat (8) step(0, 4'b1001, 1);              // aging between two requesters
    repeat (3) step(0, 4'b1110, 1);              // build up ages, then reset in BUSY
    repeat (2) step(0, 4'b1000, 0);
    step(1, 4'b1000, 0);
    repeat (3) step(0, 4'b1001, 0);
    step(0, 4'b1111, 1);                         // boundary: all requesting
    repeat (6) step(0, 4'b1111, 1);
    dv = '0;
    repeat (1500) begin
      if ($urandom_range(0, 3) == 0) dv = IW'($urandom);
      step($urandom_range(0, 99) == 0, dv, $urandom_range(0, 2) == 0);
    end
    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
